sram_bridge: RTL and testbench

Requester-side bridge that drives port a of the on-chip SRAM (single-cycle registered-address read, same-edge write) from a valid/ready request channel and returns read data on a valid/ready response channel. It sits between the core's load/store unit and the data SRAM. It hides the SRAM's one-cycle read latency, absorbs response back-pressure in a 2-entry buffer and sustains one request per cycle when the response side is not stalled.

---
 rtl/sram_bridge.sv | 105 ++++++++++
 tb/tb_sram_bridge.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_bridge.sv
// sram_bridge: valid/ready front end for port a of the on-chip data SRAM.
// Hides the SRAM's one-cycle read latency, buffers up to two responses and
// sustains one request per cycle while the response side keeps up.
// Optional build macro SRAM_BRIDGE_WRESP_EN: every accepted write also returns
// a response carrying its write data, ordered with reads in issue order.
module sram_bridge #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 256,
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0]      req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    output logic                  mem_write_en,
    input  logic [WIDTH-1:0]      mem_rdata
);

    logic             acc;
    logic             pop;
    logic             push;
    logic             issue;
    logic [WIDTH-1:0] push_data;
    logic [1:0]       occ_d;

    logic [1:0]       occ_q;
    logic             inflight_q;
    logic             wptr_q;
    logic             rptr_q;
    logic [WIDTH-1:0] fifo_q [2];

`ifdef SRAM_BRIDGE_WRESP_EN
    logic             infl_wr_q;
    logic [WIDTH-1:0] wdata_q;
`endif

    // Handshakes, SRAM drive, response head and buffer occupancy next-state
    always_comb begin
        pop       = (occ_q != 2'd0) & rsp_ready;
        // Counting the in-flight read reserves its slot; a pop frees one this cycle
        req_ready = ((occ_q + {1'b0, inflight_q}) < 2'd2) | pop;
        acc       = req_valid & req_ready & ~rst;

        mem_addr     = req_addr;
        mem_wdata    = req_wdata;
        mem_write_en = acc & req_we;

`ifdef SRAM_BRIDGE_WRESP_EN
        issue     = acc;
        push_data = infl_wr_q ? wdata_q : mem_rdata;
`else
        issue     = acc & ~req_we;
        push_data = mem_rdata;
`endif
        push = inflight_q;

        rsp_valid = (occ_q != 2'd0);
        rsp_rdata = fifo_q[rptr_q];

        case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    // In-flight tracking and response FIFO state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            wptr_q     <= 1'b0;
            rptr_q     <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
`ifdef SRAM_BRIDGE_WRESP_EN
            infl_wr_q  <= 1'b0;
            wdata_q    <= '0;
`endif
        end else begin
            occ_q      <= occ_d;
            inflight_q <= issue;
            if (push) begin
                fifo_q[wptr_q] <= push_data;
                wptr_q         <= ~wptr_q;
            end
            if (pop) begin
                rptr_q <= ~rptr_q;
            end
`ifdef SRAM_BRIDGE_WRESP_EN
            infl_wr_q  <= acc & req_we;
            wdata_q    <= req_wdata;
`endif
        end
    end

endmodule

// File: tb/tb_sram_bridge.sv
// Directed bench for sram_bridge with a behavioural SRAM (registered read
// address, same-edge write). Inputs change and outputs are sampled just after
// each falling edge.
module tb_sram_bridge;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write_en;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    sram_bridge #(
        .WIDTH (32),
        .DEPTH (256)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_write_en (mem_write_en),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM port a model
    logic [31:0] sram [256];
    logic [7:0]  sram_addr_q;
    always @(posedge clk) begin
        if (mem_write_en) sram[mem_addr] <= mem_wdata;
        sram_addr_q <= mem_addr;
    end
    assign mem_rdata = sram[sram_addr_q];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One cycle: new inputs just after the falling edge, outputs settle by #1
    task automatic drive(input logic v, input logic we, input logic [7:0] a,
                         input logic [31:0] d, input logic rr);
        @(negedge clk);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        rsp_ready = rr;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'd0, 32'd0, 1'b1);
    endtask

    // Back-pressure table, one entry per cycle
    logic       bp_rr  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic       bp_rdy [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic       bp_vld [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] bp_dat [9] = '{8'h00, 8'h00, 8'hA0, 8'hA0, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h00};

    initial begin
        int nxt;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 8'd0;
        req_wdata = 32'd0;
        rsp_ready = 1'b0;

        // Reset holds off writes even with a request present
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        #1;
        check("rst_wen", mem_write_en, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        rst       = 1'b0;
        #1;
        check("rst_ready", req_ready, 1'b1);
        check("rst_valid", rsp_valid, 1'b0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_wen0", mem_write_en, 1'b0);

        // Write then read the same address
        drive(1'b1, 1'b1, 8'd5, 32'hDEADBEEF, 1'b1);
        check("wr_ready", req_ready, 1'b1);
        check("wr_en", mem_write_en, 1'b1);
        drive(1'b1, 1'b0, 8'd5, 32'd0, 1'b1);
        check("rd_en", mem_write_en, 1'b0);
        check("rd_v0", rsp_valid, 1'b0);
        drive(1'b0, 1'b0, 8'd0, 32'd0, 1'b1);
`ifdef SRAM_BRIDGE_WRESP_EN
        check("wr_rsp_v", rsp_valid, 1'b1);
        check("wr_rsp_d", rsp_rdata, 32'hDEADBEEF);
`else
        check("rd_v1", rsp_valid, 1'b0);
`endif
        drive(1'b0, 1'b0, 8'd0, 32'd0, 1'b1);
        check("rd_v2", rsp_valid, 1'b1);
        check("rd_d2", rsp_rdata, 32'hDEADBEEF);
        drive(1'b0, 1'b0, 8'd0, 32'd0, 1'b1);
        check("rd_v3", rsp_valid, 1'b0);

        // Preload addr 0..7 with A0..A7, then stream eight reads
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 8'(i), 32'hA0 + 32'(i), 1'b1);
        idle(3);
        for (int c = 0; c < 11; c++) begin
            if (c < 8) drive(1'b1, 1'b0, 8'(c), 32'd0, 1'b1);
            else       drive(1'b0, 1'b0, 8'd0, 32'd0, 1'b1);
            if (c < 8) check($sformatf("st_rdy%0d", c), req_ready, 1'b1);
            if (c >= 2 && c < 10) begin
                check($sformatf("st_v%0d", c), rsp_valid, 1'b1);
                check($sformatf("st_d%0d", c), rsp_rdata, 32'hA0 + 32'(c - 2));
            end else begin
                check($sformatf("st_v%0d", c), rsp_valid, 1'b0);
            end
        end

        // Back-pressure: four reads offered with rsp_ready low at first
        nxt = 0;
        for (int c = 0; c < 9; c++) begin
            drive(nxt < 4, 1'b0, 8'(nxt), 32'd0, bp_rr[c]);
            check($sformatf("bp_rdy%0d", c), req_ready, bp_rdy[c]);
            check($sformatf("bp_v%0d", c), rsp_valid, bp_vld[c]);
            if (bp_vld[c]) check($sformatf("bp_d%0d", c), rsp_rdata, {24'd0, bp_dat[c]});
            if (nxt < 4 && bp_rdy[c]) nxt++;
        end
        check("bp_all", nxt, 4);

        // Read then write same address: read sees old data
        drive(1'b1, 1'b1, 8'd3, 32'h11, 1'b1);
        idle(3);
        drive(1'b1, 1'b0, 8'd3, 32'd0, 1'b1);
        drive(1'b1, 1'b1, 8'd3, 32'h22, 1'b1);
        check("rw_wen", mem_write_en, 1'b1);
        drive(1'b0, 1'b0, 8'd0, 32'd0, 1'b1);
        check("rw_v", rsp_valid, 1'b1);
        check("rw_old", rsp_rdata, 32'h11);
        drive(1'b1, 1'b0, 8'd3, 32'd0, 1'b1);
`ifdef SRAM_BRIDGE_WRESP_EN
        check("rw_wv", rsp_valid, 1'b1);
        check("rw_wd", rsp_rdata, 32'h22);
`else
        check("rw_v1", rsp_valid, 1'b0);
`endif
        drive(1'b0, 1'b0, 8'd0, 32'd0, 1'b1);
        drive(1'b0, 1'b0, 8'd0, 32'd0, 1'b1);
        check("rw_nv", rsp_valid, 1'b1);
        check("rw_new", rsp_rdata, 32'h22);

        // Reset with two reads accepted and held back by rsp_ready low
        idle(2);
        drive(1'b1, 1'b0, 8'd0, 32'd0, 1'b0);
        drive(1'b1, 1'b0, 8'd1, 32'd0, 1'b0);
        drive(1'b0, 1'b0, 8'd0, 32'd0, 1'b0);
        check("pre_v", rsp_valid, 1'b1);
        check("pre_rdy", req_ready, 1'b0);
        rst = 1'b1;
        #1;
        check("ar_v", rsp_valid, 1'b0);
        check("ar_rdy", req_ready, 1'b1);
        check("ar_d", rsp_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 1'b0, 8'd0, 32'd0, 1'b1);
            check($sformatf("post_v%0d", c), rsp_valid, 1'b0);
        end

`ifdef SRAM_BRIDGE_WRESP_EN
        // Write response carries the write data two cycles after accept
        drive(1'b1, 1'b1, 8'd9, 32'h55, 1'b1);
        drive(1'b0, 1'b0, 8'd0, 32'd0, 1'b1);
        check("wresp_v1", rsp_valid, 1'b0);
        drive(1'b0, 1'b0, 8'd0, 32'd0, 1'b1);
        check("wresp_v2", rsp_valid, 1'b1);
        check("wresp_d", rsp_rdata, 32'h55);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
